// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter
// Shares one barrier gate between the entry and exit lanes. Each lane's motion
// signal is debounced into a single latched request per car. Requests are
// arbitrated round-robin. The gate is sequenced open -> wait-for-clear -> close,
// and the occupancy count is updated when a service completes.
module parking_gate_arbiter #(
   parameter int CAPACITY      = 16,
   parameter int CNT_W         = 5,
   parameter int DEBOUNCE      = 4,
   parameter int OPEN_TIME     = 8,
   parameter int CLEAR_TIMEOUT = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             entry_motion,
   input  logic             exit_motion,
   output logic             gate_open,
   output logic             grant_entry,
   output logic             grant_exit,
   output logic [CNT_W-1:0] occupancy,
   output logic             full,
   output logic             busy,
   output logic             timeout
);

   localparam logic L_ENTRY = 1'b0;
   localparam logic L_EXIT  = 1'b1;

   localparam int DB_W    = $clog2(DEBOUNCE + 1);
   localparam int TMR_MAX = (OPEN_TIME > CLEAR_TIMEOUT) ? OPEN_TIME : CLEAR_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_OPEN, S_WAIT, S_CLOSE} state_t;

   // lane 0 = entry, lane 1 = exit
   logic [1:0] motion;
   assign motion = {exit_motion, entry_motion};

   logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
   logic [1:0]           armed_q, armed_d;
   logic [1:0]           pend_q, pend_d;
   logic [1:0]           pend_clr;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             served_q, served_d;
   logic             rr_q, rr_d;       // lane served last
   logic [CNT_W-1:0] occ_q, occ_d;

   logic gate_open_q, gate_open_d;
   logic grant_entry_q, grant_entry_d;
   logic grant_exit_q, grant_exit_d;
   logic full_q, full_d;
   logic busy_q, busy_d;
   logic timeout_q, timeout_d;

   logic elig_entry, elig_exit;

   assign elig_entry = pend_q[L_ENTRY] && !full_q;
   assign elig_exit  = pend_q[L_EXIT] && (occ_q != '0);

   // Debounce: count consecutive high samples and saturate. A request is raised
   // once per qualification and only re-armed by a low sample. A qualification
   // that lands on a grant edge wins over the clear, so it is not lost.
   always_comb begin
      db_cnt_d = db_cnt_q;
      armed_d  = armed_q;
      pend_d   = pend_q & ~pend_clr;
      for (int l = 0; l < 2; l++) begin
         if (!motion[l]) begin
            db_cnt_d[l] = '0;
            armed_d[l]  = 1'b1;
         end else if (db_cnt_q[l] != DB_W'(DEBOUNCE)) begin
            db_cnt_d[l] = db_cnt_q[l] + DB_W'(1);
            if (db_cnt_q[l] == DB_W'(DEBOUNCE - 1) && armed_q[l]) begin
               pend_d[l]  = 1'b1;
               armed_d[l] = 1'b0;
            end
         end
      end
   end

   // Debounce counters, arming and pending request flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt_q <= '0;
         armed_q  <= 2'b11;
         pend_q   <= 2'b00;
      end else begin
         db_cnt_q <= db_cnt_d;
         armed_q  <= armed_d;
         pend_q   <= pend_d;
      end
   end

   // FSM state, phase timer, served lane, RR pointer and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         tmr_q    <= '0;
         served_q <= L_ENTRY;
         rr_q     <= L_EXIT;   // entry wins the first tie
         occ_q    <= '0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         served_q <= served_d;
         rr_q     <= rr_d;
         occ_q    <= occ_d;
      end
   end

   // Next state: arbitration in IDLE, timed OPEN, wait for clear, one-cycle CLOSE
   always_comb begin
      state_d  = state_q;
      tmr_d    = '0;
      served_d = served_q;
      rr_d     = rr_q;
      occ_d    = occ_q;
      pend_clr = 2'b00;
      case (state_q)
         S_IDLE: begin
            // An exit request with nobody parked can never be served.
            if (pend_q[L_EXIT] && occ_q == '0) pend_clr[L_EXIT] = 1'b1;
            if (elig_entry && (!elig_exit || rr_q == L_EXIT)) begin
               served_d          = L_ENTRY;
               state_d           = S_OPEN;
               pend_clr[L_ENTRY] = 1'b1;
            end else if (elig_exit) begin
               served_d         = L_EXIT;
               state_d          = S_OPEN;
               pend_clr[L_EXIT] = 1'b1;
            end
         end
         S_OPEN: begin
            if (tmr_q == TMR_W'(OPEN_TIME - 1)) state_d = S_WAIT;
            else                                tmr_d   = tmr_q + TMR_W'(1);
         end
         S_WAIT: begin
            if (!motion[served_q])                         state_d = S_CLOSE;
            else if (tmr_q == TMR_W'(CLEAR_TIMEOUT - 1))   state_d = S_CLOSE;
            else                                           tmr_d   = tmr_q + TMR_W'(1);
         end
         S_CLOSE: begin
            state_d = S_IDLE;
            rr_d    = served_q;
            // Eligibility rules guarantee no overflow/underflow here.
            occ_d   = (served_q == L_ENTRY) ? occ_q + CNT_W'(1) : occ_q - CNT_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the next state so outputs move on the same edge as state
   always_comb begin
      gate_open_d   = (state_d == S_OPEN) || (state_d == S_WAIT);
      busy_d        = (state_d != S_IDLE);
      grant_entry_d = busy_d && (served_d == L_ENTRY);
      grant_exit_d  = busy_d && (served_d == L_EXIT);
      full_d        = (occ_d == CNT_W'(CAPACITY));
      timeout_d     = (state_q == S_WAIT) && (state_d == S_CLOSE) && motion[served_q];
   end

   // Registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_open_q   <= 1'b0;
         grant_entry_q <= 1'b0;
         grant_exit_q  <= 1'b0;
         full_q        <= 1'b0;
         busy_q        <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         gate_open_q   <= gate_open_d;
         grant_entry_q <= grant_entry_d;
         grant_exit_q  <= grant_exit_d;
         full_q        <= full_d;
         busy_q        <= busy_d;
         timeout_q     <= timeout_d;
      end
   end

   assign gate_open   = gate_open_q;
   assign grant_entry = grant_entry_q;
   assign grant_exit  = grant_exit_q;
   assign occupancy   = occ_q;
   assign full        = full_q;
   assign busy        = busy_q;
   assign timeout     = timeout_q;

endmodule
